// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// bcd_serial_adder_ctrl_pkg: shared state encodings, BCD constants and digit checks
package bcd_serial_adder_ctrl_pkg;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN = 1'b1;
    localparam int BCD_W = 4;
    localparam logic [3:0] CORR = 4'd6;
    function automatic logic bcd_bad(input logic [BCD_W-1:0] v);
        return v > 4'd9;
    endfunction
endpackage

// File: rtl/bcd_serial_adder_ctrl_digit_add.sv
// bcd_digit_add: combinational one-digit BCD add with decimal correction
module bcd_digit_add
    import bcd_serial_adder_ctrl_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c,
    output logic [3:0] d,
    output logic       co
);
    logic [4:0] s;
    logic       k;
    assign s  = {1'b0, x} + {1'b0, y} + {4'b0, c};
    assign k  = s[4] | (s[3] & (s[2] | s[1]));
    assign d  = s[3:0] + (k ? CORR : 4'd0);
    assign co = k;
endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: multi-digit BCD adder reusing one digit stage, LSD first
module bcd_serial_adder_ctrl
    import bcd_serial_adder_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] sum,
    output logic                    cout,
    output logic                    err
);
    localparam int W  = BCD_W * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);

    logic [0:0]    state;
    logic [W-1:0]  ra, rb, rs, rs_next;
    logic [IW-1:0] idx;
    logic          carry, err_st, bad, last, co;
    logic [3:0]    d;

    bcd_digit_add u_dig (
        .x (ra[3:0]),
        .y (rb[3:0]),
        .c (carry),
        .d (d),
        .co(co)
    );

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | bcd_bad(a[i*BCD_W +: BCD_W]) | bcd_bad(b[i*BCD_W +: BCD_W]);
    end

    assign busy    = state == RUN;
    assign last    = idx == IW'(DIGITS - 1);
    // new digit enters at the top so digit 0 ends up in the low nibble
    assign rs_next = W'({d, rs} >> BCD_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            rs     <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            err_st <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state  <= RUN;
                    ra     <= a;
                    rb     <= b;
                    carry  <= cin;
                    err_st <= bad;
                    idx    <= '0;
                end
            end else begin
                ra    <= ra >> BCD_W;
                rb    <= rb >> BCD_W;
                rs    <= rs_next;
                carry <= co;
                idx   <= idx + IW'(1);
                if (last) begin
                    state <= IDLE;
                    sum   <= rs_next;
                    cout  <= co;
                    err   <= err_st;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl: randomized and directed checks against a decimal reference model
module tb_bcd_serial_adder_ctrl;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;
    int           n_chk = 0;
    int           n_pass = 0;

    bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .err  (err)
    );

    always #5 clk = ~clk;

    // digit rule: t = x+y+c; carry when t>9; digit is t+6 mod 16 on carry
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                  output logic [W-1:0] s, output logic co, output logic e);
        int t, xd, yd;
        co = ci;
        e  = 1'b0;
        s  = '0;
        for (int i = 0; i < D; i++) begin
            xd = int'(x[i*4 +: 4]);
            yd = int'(y[i*4 +: 4]);
            e  = e | (xd > 9) | (yd > 9);
            t  = xd + yd + int'(co);
            co = t > 9;
            s[i*4 +: 4] = co ? 4'((t + 6) % 16) : 4'(t);
        end
    endfunction

    function automatic int to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          output int lat, output int bc);
        a = x;
        b = y;
        cin = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bc  = busy ? 1 : 0;
        lat = 0;
        for (int c = 1; c <= 3 * D; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
            bc += busy ? 1 : 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, done, sum, cout, err} !== '0)
            $display("FAIL reset_hold: got busy=%b done=%b sum=%h cout=%b err=%b want all 0", busy, done, sum, cout, err);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if ({busy, done, sum, cout, err} !== '0)
            $display("FAIL reset_release: got busy=%b done=%b sum=%h cout=%b err=%b want all 0", busy, done, sum, cout, err);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5] = '{16'h1234, 16'h9999, 16'h9999, 16'h00A0, 16'h1111};
        logic [W-1:0] vb[5] = '{16'h5678, 16'h0001, 16'h9999, 16'h0000, 16'h2222};
        logic         vc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] es[5] = '{16'h6912, 16'h0000, 16'h9999, 16'h0100, 16'h3333};
        logic         eo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic         ee[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], lat, bc);
            n_chk++;
            if (lat !== D || bc !== D || busy !== 1'b0)
                $display("FAIL dir_timing[%0d]: got lat=%0d busy_cycles=%0d busy_at_done=%b want %0d %0d 0", i, lat, bc, busy, D, D);
            else n_pass++;
            n_chk++;
            if ({sum, cout, err} !== {es[i], eo[i], ee[i]})
                $display("FAIL dir_result[%0d]: got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b", i, sum, cout, err, es[i], eo[i], ee[i]);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (done !== 1'b0) $display("FAIL done_pulse_width: got done=%b want 0", done);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, es;
        logic ci, eo, ee;
        int lat, bc, tot;
        for (int i = 0; i < 30; i++) begin
            x  = (i < 20) ? rand_bcd() : W'($urandom);
            y  = (i < 20) ? rand_bcd() : W'($urandom);
            ci = 1'($urandom);
            model(x, y, ci, es, eo, ee);
            run_op(x, y, ci, lat, bc);
            n_chk++;
            if (lat !== D || {sum, cout, err} !== {es, eo, ee})
                $display("FAIL rand[%0d] %h+%h+%b: got lat=%0d sum=%h cout=%b err=%b want lat=%0d sum=%h cout=%b err=%b",
                         i, x, y, ci, lat, sum, cout, err, D, es, eo, ee);
            else n_pass++;
            if (i < 20) begin
                tot = to_int(x) + to_int(y) + int'(ci);
                n_chk++;
                if (to_int(sum) + (cout ? 10 ** D : 0) !== tot)
                    $display("FAIL rand_decimal[%0d]: got %0d want %0d", i, to_int(sum) + (cout ? 10 ** D : 0), tot);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hold_start();
        logic [W-1:0] es;
        logic eo, ee, xd;
        model(16'h0005, 16'h0005, 1'b0, es, eo, ee);
        a = 16'h0005;
        b = 16'h0005;
        cin = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 3 * (D + 1); c++) begin
            @(posedge clk);
            #1;
            xd = (c % (D + 1)) == D;
            n_chk++;
            if (done !== xd || busy !== !xd)
                $display("FAIL hold_start_cyc%0d: got done=%b busy=%b want done=%b busy=%b", c, done, busy, xd, !xd);
            else n_pass++;
            if (xd) begin
                n_chk++;
                if ({sum, cout, err} !== {es, eo, ee})
                    $display("FAIL hold_start_sum%0d: got %h/%b/%b want %h/%b/%b", c, sum, cout, err, es, eo, ee);
                else n_pass++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_mid_change();
        logic [W-1:0] x, y, es, prev;
        logic ci, eo, ee;
        int lat;
        x = rand_bcd();
        y = rand_bcd();
        ci = 1'($urandom);
        model(x, y, ci, es, eo, ee);
        prev = sum;
        a = x;
        b = y;
        cin = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 3 * D; c++) begin
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
            n_chk++;
            if (sum !== prev) $display("FAIL mid_hold_c%0d: got sum=%h want %h", c, sum, prev);
            else n_pass++;
        end
        n_chk++;
        if (lat !== D || {sum, cout, err} !== {es, eo, ee})
            $display("FAIL mid_change: got lat=%0d sum=%h cout=%b err=%b want lat=%0d sum=%h cout=%b err=%b", lat, sum, cout, err, D, es, eo, ee);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, bc, nd;
        run_op(16'h4321, 16'h1111, 1'b0, lat, bc);
        n_chk++;
        if (sum !== 16'h5432) $display("FAIL pre_reset_sum: got %h want 5432", sum);
        else n_pass++;
        a = 16'h9999;
        b = 16'h9999;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({busy, done, sum, cout, err} !== '0)
            $display("FAIL reset_mid_async: got busy=%b done=%b sum=%h cout=%b err=%b want all 0", busy, done, sum, cout, err);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < D + 2; c++) begin
            @(posedge clk);
            #1;
            nd += done ? 1 : 0;
        end
        n_chk++;
        if (nd !== 0 || busy !== 1'b0) $display("FAIL reset_mid_no_done: got done_count=%0d busy=%b want 0 0", nd, busy);
        else n_pass++;
        run_op(16'h0789, 16'h0211, 1'b0, lat, bc);
        n_chk++;
        if (lat !== D || {sum, cout, err} !== {16'h1000, 1'b0, 1'b0})
            $display("FAIL reset_mid_recover: got lat=%0d sum=%h cout=%b err=%b want lat=%0d sum=1000 cout=0 err=0", lat, sum, cout, err, D);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold_start();
        test_mid_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
